trng_crngt: RTL and testbench

//  Continuous random-number-generator test (CRNGT) stage between the bit collector and the EHR.

---
 rtl/trng_crngt.sv | 112 +++++++++++
 tb/tb_trng_crngt.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/trng_crngt.sv
// Continuous RNG test stage: drops any 16-bit collector word equal to its predecessor,
// forwards the rest to the EHR with a slot counter, and flags EHR-full to the CPU side.
module trng_crngt #(
   parameter int EHR_WIDTH = 128,
   parameter int ERR_CNT_W = 8
) (
   input  logic                 rng_clk,
   input  logic                 rst_trng_logic,
   input  logic [15:0]          collector_dout,
   input  logic                 collector_valid,
   input  logic                 trng_crngt_bypass,
   input  logic                 ehr_rd_done,
   output logic                 crngt_rd_collector,
   output logic [15:0]          crngt_dout,
   output logic                 crngt_valid,
   output logic                 curr_test_err,
   output logic [7:0]           bits_counter,
   output logic                 trng_valid,
   output logic [ERR_CNT_W-1:0] crngt_err_cnt
);
   typedef enum logic {ST_ARM = 1'b0, ST_RUN = 1'b1} state_t;

   localparam logic [7:0] LAST_SLOT = 8'(EHR_WIDTH - 16);

   state_t               r_state;
   state_t               w_state_next;
   logic [15:0]          r_prev;
   logic [15:0]          r_dout;
   logic                 r_valid;
   logic                 r_err;
   logic                 r_full;
   logic [7:0]           r_bits;
   logic [ERR_CNT_W-1:0] r_err_cnt;
   logic                 w_accept;
   logic                 w_seed;
   logic                 w_pass;
   logic                 w_fail;
   logic                 w_advance;
   logic                 w_wrap;

   // One word per two cycles at most: the output pulses themselves block acceptance.
   assign w_accept           = collector_valid & ~r_full & ~r_valid & ~r_err;
   assign crngt_rd_collector = w_accept & ~trng_crngt_bypass;
   assign w_advance          = r_valid | (trng_crngt_bypass & collector_valid & ~r_full);
   assign w_wrap             = (r_bits == LAST_SLOT);

   always_comb begin
      w_state_next = r_state;
      w_seed       = 1'b0;
      w_pass       = 1'b0;
      w_fail       = 1'b0;
      if (trng_crngt_bypass) begin
         w_state_next = ST_ARM;
      end else if (w_accept) begin
         if (r_state == ST_ARM) begin
            w_seed       = 1'b1;
            w_state_next = ST_RUN;
         end else if (collector_dout == r_prev) begin
            w_fail       = 1'b1;
            w_state_next = ST_ARM;
         end else begin
            w_pass       = 1'b1;
         end
      end
   end

   always_ff @(posedge rng_clk) begin
      if (rst_trng_logic) begin
         r_state   <= ST_ARM;
         r_prev    <= '0;
         r_dout    <= '0;
         r_valid   <= 1'b0;
         r_err     <= 1'b0;
         r_full    <= 1'b0;
         r_bits    <= '0;
         r_err_cnt <= '0;
      end else begin
         r_state <= w_state_next;
         r_valid <= w_pass;
         r_err   <= w_fail;
         if (w_seed || w_pass) begin
            r_prev <= collector_dout;
         end
         if (w_pass) begin
            r_dout <= collector_dout;
         end
         // A repeat zeroes the EHR, so the fill restarts from slot 0.
         if (w_fail) begin
            r_bits <= '0;
         end else if (w_advance) begin
            r_bits <= w_wrap ? 8'd0 : r_bits + 8'd16;
         end
         if (w_fail) begin
            r_full <= 1'b0;
         end else if (w_advance && w_wrap) begin
            r_full <= 1'b1;
         end else if (ehr_rd_done) begin
            r_full <= 1'b0;
         end
         if (w_fail && (r_err_cnt != '1)) begin
            r_err_cnt <= r_err_cnt + 1'b1;
         end
      end
   end

   assign crngt_dout    = r_dout;
   assign crngt_valid   = r_valid;
   assign curr_test_err = r_err;
   assign bits_counter  = r_bits;
   assign trng_valid    = r_full;
   assign crngt_err_cnt = r_err_cnt;
endmodule

// File: tb/tb_trng_crngt.sv
// Bench for trng_crngt: directed scenarios with literal expectations, then random
// traffic, all outputs compared every cycle against a slot/word-level model.
module tb_trng_crngt;
   localparam int NSLOT = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] cdout;
   logic        cvalid;
   logic        bypass;
   logic        rd_done;
   logic        rd_coll;
   logic [15:0] dout;
   logic        valid;
   logic        err;
   logic [7:0]  bits;
   logic        tvalid;
   logic [7:0]  ecnt;

   int n_vec = 0;
   int n_mis = 0;

   trng_crngt #(.EHR_WIDTH(128), .ERR_CNT_W(8)) dut (
      .rng_clk           (clk),
      .rst_trng_logic    (rst),
      .collector_dout    (cdout),
      .collector_valid   (cvalid),
      .trng_crngt_bypass (bypass),
      .ehr_rd_done       (rd_done),
      .crngt_rd_collector(rd_coll),
      .crngt_dout        (dout),
      .crngt_valid       (valid),
      .curr_test_err     (err),
      .bits_counter      (bits),
      .trng_valid        (tvalid),
      .crngt_err_cnt     (ecnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: word-level view of the stage (seeded flag, last word, slot number, EHR full).
   bit          model_live = 0;
   bit          m_seeded, m_full, m_vp, m_ep;
   logic [15:0] m_prev, m_dout;
   int          m_slot, m_errs;

   always @(posedge clk) begin
      if (rst) begin
         model_live = 1;
         m_seeded = 0; m_full = 0; m_vp = 0; m_ep = 0;
         m_prev = 0; m_dout = 0; m_slot = 0; m_errs = 0;
      end else if (model_live) begin
         bit take, adv, nv, ne;
         take = cvalid && !m_full && !m_vp && !m_ep;
         adv  = m_vp || (bypass && cvalid && !m_full);
         nv = 0; ne = 0;
         if (rd_done) m_full = 0;
         if (bypass) begin
            m_seeded = 0;
         end else if (take) begin
            if (!m_seeded) begin
               m_prev = cdout; m_seeded = 1;
            end else if (cdout == m_prev) begin
               ne = 1; m_seeded = 0; m_slot = 0; m_full = 0;
               m_errs = (m_errs < 255) ? m_errs + 1 : 255;
            end else begin
               nv = 1; m_dout = cdout; m_prev = cdout;
            end
         end
         if (adv) begin
            m_slot = m_slot + 1;
            if (m_slot == NSLOT) begin
               m_slot = 0; m_full = 1;
            end
         end
         m_vp = nv; m_ep = ne;
      end
   end

   always @(negedge clk) begin
      if (model_live) begin
         chk("rd_collector", rd_coll, cvalid && !m_full && !m_vp && !m_ep && !bypass);
         chk("crngt_dout", dout, m_dout);
         chk("crngt_valid", valid, m_vp);
         chk("curr_test_err", err, m_ep);
         chk("bits_counter", bits, m_slot * 16);
         chk("trng_valid", tvalid, m_full);
         chk("err_cnt", ecnt, m_errs);
      end
   end

   logic [7:0] slot_q[$];
   int n_vp = 0;
   int n_ep = 0;
   always @(negedge clk) begin
      if (valid) begin
         slot_q.push_back(bits);
         n_vp++;
      end
      if (err) n_ep++;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1; cvalid = 0; rd_done = 0;
      tick(2);
      rst = 0;
   endtask

   // Present a word until the DUT strobes it, then drop valid.
   task automatic push(input logic [15:0] w);
      int n = 0;
      cdout = w; cvalid = 1;
      @(negedge clk);
      while (!rd_coll && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) begin
         n_vec++; n_mis++;
         $display("FAIL push_timeout: got no strobe expected strobe for %h", w);
      end
      tick(1);
      cvalid = 0;
   endtask

   task automatic push_byp(input logic [15:0] w);
      int n = 0;
      cdout = w; cvalid = 1;
      @(negedge clk);
      while (tvalid && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) begin
         n_vec++; n_mis++;
         $display("FAIL push_byp_timeout: got full expected not full");
      end
      tick(1);
      cvalid = 0;
   endtask

   initial begin
      int vp0, ep0;
      rst = 1; cdout = 0; cvalid = 0; bypass = 0; rd_done = 0;
      @(posedge clk); #1;
      do_reset();
      @(negedge clk);
      chk("reset_bits", bits, 0);
      chk("reset_tvalid", tvalid, 0);
      chk("reset_ecnt", ecnt, 0);
      tick(1);

      // Fill the EHR: first word seeds only, then 8 slots.
      slot_q.delete();
      for (int k = 1; k <= 9; k++) push(16'(k * 16'h1111));
      tick(1);
      chk("fill_pulses", slot_q.size(), 8);
      for (int i = 0; i < 8 && i < slot_q.size(); i++) chk("fill_slot", slot_q[i], i * 16);
      chk("fill_tvalid", tvalid, 1);
      chk("fill_bits", bits, 0);
      chk("fill_dout", dout, 16'h9999);

      // Full EHR blocks input until read.
      cdout = 16'hAAAA; cvalid = 1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("full_no_strobe", rd_coll, 0);
         tick(1);
      end
      rd_done = 1;
      tick(1);
      rd_done = 0;
      chk("rd_done_clears", tvalid, 0);
      slot_q.delete();
      push(16'hAAAA);
      tick(1);
      chk("after_read_pulses", slot_q.size(), 1);
      if (slot_q.size() > 0) chk("after_read_slot", slot_q[0], 0);

      // Repeat detection.
      do_reset();
      ep0 = n_ep; vp0 = n_vp;
      push(16'hA5A5); push(16'h1234); push(16'h1234);
      tick(1);
      chk("rep_err_pulses", n_ep - ep0, 1);
      chk("rep_err_cnt", ecnt, 1);
      chk("rep_bits", bits, 0);
      push(16'h1234);
      tick(2);
      chk("rearm_no_err", n_ep - ep0, 1);
      chk("rearm_no_valid", n_vp - vp0, 1);

      // Bypass: repeated words fill the EHR with no pulses.
      do_reset();
      bypass = 1;
      ep0 = n_ep; vp0 = n_vp;
      for (int k = 0; k < 8; k++) push_byp(16'h5555);
      @(negedge clk);
      chk("byp_tvalid", tvalid, 1);
      chk("byp_bits", bits, 0);
      chk("byp_no_valid", n_vp - vp0, 0);
      chk("byp_no_err", n_ep - ep0, 0);
      tick(1);
      rd_done = 1; tick(1); rd_done = 0;
      bypass = 0;

      // Error counter saturation.
      do_reset();
      ep0 = n_ep;
      for (int k = 0; k < 260; k++) begin
         push(16'h0001);
         push(16'h0001);
      end
      tick(2);
      chk("sat_err_pulses", n_ep - ep0, 260);
      chk("sat_err_cnt", ecnt, 8'hFF);

      // Reset coinciding with an accepted repeat.
      do_reset();
      push(16'h1111);
      ep0 = n_ep;
      cdout = 16'h1111; cvalid = 1; rst = 1;
      tick(1);
      rst = 0; cvalid = 0;
      @(negedge clk);
      chk("rst_err", err, 0);
      chk("rst_valid", valid, 0);
      chk("rst_ecnt", ecnt, 0);
      chk("rst_bits", bits, 0);
      chk("rst_dout", dout, 0);
      tick(1);
      chk("rst_no_err_pulse", n_ep - ep0, 0);

      // Random traffic against the model.
      for (int c = 0; c < 4000; c++) begin
         rst     = ($urandom_range(0, 299) == 0);
         cvalid  = ($urandom_range(0, 2) != 0);
         cdout   = 16'($urandom_range(0, 3)) * 16'h1111;
         rd_done = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 99) == 0) bypass = ~bypass;
         tick(1);
      end
      rst = 0; cvalid = 0; rd_done = 0;
      tick(2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end
endmodule
